// File: rtl/modulo_counter.sv
// modulo_counter
//   Synchronous modulo-MODULUS up-counter with count enable and parallel load.
//   `number` runs 0 .. MODULUS-1 and wraps to 0. It is the position/timebase
//   for downstream window comparators.
//
// Parameters
//   MODULUS : count modulus, 2 .. 2**16
//   WIDTH   : width of number/data, derived as $clog2(MODULUS)
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, forces count to 0
//   incr     : count enable, advance by one per edge
//   set_data : parallel-load strobe, level sampled (tie to 0 when unused)
//   data     : load value; out-of-range loads (>= MODULUS) give 0
//   number   : current count, straight from the count register
//
// Edge priority: rst > set_data > incr > hold.
module modulo_counter #(
  parameter int unsigned MODULUS = 1024,
  parameter int unsigned WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  input  logic             set_data,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] number
);

  // Modulus held at WIDTH+1 bits so 2**WIDTH itself is representable.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   count_inc;
  logic             at_last;
  logic             data_ok;

  always_comb begin
    // Increment carried at WIDTH+1 bits: count+1 == MODULUS is exactly
    // count == MODULUS-1, and it cannot overflow for power-of-two moduli.
    count_inc = {1'b0, count_q} + ONE_EXT;
    at_last   = (count_inc == MOD_EXT);
    data_ok   = ({1'b0, data} < MOD_EXT);

    count_d = count_q;
    if (set_data) begin
      // Load wins over incr; an illegal value collapses to 0 so the count
      // never leaves 0 .. MODULUS-1.
      count_d = data_ok ? data : '0;
    end else if (incr) begin
      count_d = at_last ? '0 : count_inc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign number = count_q;

endmodule

// File: tb/tb_modulo_counter.sv
module tb_modulo_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MODULUS=1024 instance
  logic       rst = 1'b0, incr = 1'b0, set_data = 1'b0;
  logic [9:0] data = '0;
  logic [9:0] number;
  // MODULUS=10 instance
  logic       rst10 = 1'b0, incr10 = 1'b0, set10 = 1'b0;
  logic [3:0] data10 = '0;
  logic [3:0] number10;

  modulo_counter #(.MODULUS(1024)) dut (
    .clk(clk), .rst(rst), .incr(incr), .set_data(set_data),
    .data(data), .number(number)
  );

  modulo_counter #(.MODULUS(10)) dut10 (
    .clk(clk), .rst(rst10), .incr(incr10), .set_data(set10),
    .data(data10), .number(number10)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected value pushed when stimulus is driven, popped
  // when the DUT output is sampled after the edge.
  logic [15:0] sb_q[$];

  typedef struct {
    logic       r;
    logic       s;
    logic [9:0] d;
    logic       i;
    logic [9:0] e;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic r, input logic s,
                      input logic [9:0] d, input logic i, input logic [9:0] e);
    @(negedge clk);
    rst = r; set_data = s; data = d; incr = i;
    sb_q.push_back({6'd0, e});
    @(posedge clk);
    #1;
    chk(name, {6'd0, number}, sb_q.pop_front());
  endtask

  task automatic step10(input string name, input logic r, input logic s,
                        input logic [3:0] d, input logic i, input logic [3:0] e);
    @(negedge clk);
    rst10 = r; set10 = s; data10 = d; incr10 = i;
    sb_q.push_back({12'd0, e});
    @(posedge clk);
    #1;
    chk(name, {12'd0, number10}, sb_q.pop_front());
  endtask

  initial begin
    int hits, run, maxrun, mx;

    // reset hold, release, priority, hold, load
    vecs[0] = '{1'b1, 1'b0, 10'd0,    1'b1, 10'd0};
    vecs[1] = '{1'b1, 1'b0, 10'd0,    1'b1, 10'd0};
    vecs[2] = '{1'b1, 1'b0, 10'd0,    1'b1, 10'd0};
    vecs[3] = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd1};
    vecs[4] = '{1'b0, 1'b0, 10'd0,    1'b1, 10'd2};
    vecs[5] = '{1'b1, 1'b1, 10'd5,    1'b1, 10'd0};
    vecs[6] = '{1'b0, 1'b1, 10'd5,    1'b1, 10'd5};
    vecs[7] = '{1'b0, 1'b0, 10'd0,    1'b0, 10'd5};
    vecs[8] = '{1'b0, 1'b1, 10'd1000, 1'b1, 10'd1000};
    vecs[9] = '{1'b1, 1'b0, 10'd0,    1'b0, 10'd0};

    for (int v = 0; v < 10; v++)
      step($sformatf("vec%0d", v), vecs[v].r, vecs[v].s, vecs[v].d, vecs[v].i, vecs[v].e);

    // enable gating at 37
    for (int k = 1; k <= 37; k++) step("count_up", 1'b0, 1'b0, 10'd0, 1'b1, 10'(k));
    for (int k = 0; k < 5; k++)   step("gate_hold", 1'b0, 1'b0, 10'd0, 1'b0, 10'd37);
    step("gate_resume", 1'b0, 1'b0, 10'd0, 1'b1, 10'd38);

    // load near the top then wrap
    step("load_1000", 1'b0, 1'b1, 10'd1000, 1'b1, 10'd1000);
    for (int k = 1001; k <= 1023; k++) step("load_run", 1'b0, 1'b0, 10'd0, 1'b1, 10'(k));
    step("load_wrap", 1'b0, 1'b0, 10'd0, 1'b1, 10'd0);

    // held set_data reloads every cycle, incr discarded
    step("hold_set_a", 1'b0, 1'b1, 10'd500, 1'b0, 10'd500);
    step("hold_set_b", 1'b0, 1'b1, 10'd501, 1'b1, 10'd501);
    step("hold_set_c", 1'b0, 1'b1, 10'd501, 1'b1, 10'd501);

    // reset mid-count, then a full free-run period with window tracking
    step("mid_reset", 1'b1, 1'b1, 10'd7, 1'b1, 10'd0);
    hits = 0; run = 0; maxrun = 0;
    for (int k = 1; k <= 1024; k++) begin
      step("freerun", 1'b0, 1'b0, 10'd0, 1'b1, 10'(k % 1024));
      if (number >= 10'd100 && number < 10'd200) begin
        hits++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("window_hits", 16'(hits), 16'd100);
    chk("window_run", 16'(maxrun), 16'd100);
    step("freerun_again", 1'b0, 1'b0, 10'd0, 1'b1, 10'd1);

    // MODULUS=10 build
    step10("m10_reset", 1'b1, 1'b0, 4'd0, 1'b1, 4'd0);
    mx = 0;
    for (int k = 1; k <= 50; k++) begin
      step10("m10_run", 1'b0, 1'b0, 4'd0, 1'b1, 4'(k % 10));
      if (int'(number10) > mx) mx = int'(number10);
    end
    chk("m10_max", 16'(mx), 16'd9);
    step10("m10_load12", 1'b0, 1'b1, 4'd12, 1'b1, 4'd0);
    step10("m10_load15", 1'b0, 1'b1, 4'd15, 1'b0, 4'd0);
    step10("m10_load9",  1'b0, 1'b1, 4'd9,  1'b1, 4'd9);
    step10("m10_wrap",   1'b0, 1'b0, 4'd0,  1'b1, 4'd0);
    step10("m10_load3",  1'b0, 1'b1, 4'd3,  1'b1, 4'd3);
    step10("m10_rst",    1'b1, 1'b1, 4'd3,  1'b1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
